// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera capture front end.
package cam_pkg;

    typedef enum logic [1:0] {
        WAIT_VS    = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2,
        DROP       = 2'd3
    } cam_state_t;

    // Number of pixels packed into one FIFO word.
    function automatic int ppw(input int pix_width, input int data_width);
        return data_width / pix_width;
    endfunction

    // True when value is a non-zero whole multiple of unit.
    function automatic bit is_multiple(input int value, input int unit);
        return (unit > 0) && (value >= unit) && ((value % unit) == 0);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Registers one camera sync input and derives rise/fall pulses from the registered copy.
module sync_edge (
    input  logic wr_clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_q;
    logic r_q_d;

    // Input register plus a one-cycle history used for edge detection.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            r_q   <= 1'b0;
            r_q_d <= 1'b0;
        end else begin
            r_q   <= i_d;
            r_q_d <= r_q;
        end
    end

    assign o_level = r_q;
    assign o_rise  = r_q & ~r_q_d;
    assign o_fall  = ~r_q & r_q_d;

endmodule

// File: rtl/cam_fifo_writer.sv
// Frames the camera pixel stream, packs pixels into FIFO words and reports frame status.
module cam_fifo_writer
    import cam_pkg::*;
#(
    parameter int PIX_WIDTH  = 16,
    parameter int DATA_WIDTH = 64,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  i_vsync,
    input  logic                  i_href,
    input  logic                  i_pix_valid,
    input  logic [PIX_WIDTH-1:0]  i_pix_data,
    input  logic                  i_fifo_full,
    input  logic                  i_fifo_prog_full,
    output logic                  o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0] o_fifo_din,
    output logic                  o_frame_start,
    output logic                  o_frame_done,
    output logic                  o_frame_skip,
    output logic                  o_overflow,
    output logic                  o_line_err,
    output logic [15:0]           o_frame_cnt
);

    localparam int PPW       = ppw(PIX_WIDTH, DATA_WIDTH);
    localparam int K_W       = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PIX_CNT_W = $clog2(H_ACTIVE) + 1;
    localparam int LINE_W    = $clog2(V_ACTIVE) + 1;

    if (!is_multiple(DATA_WIDTH, PIX_WIDTH)) begin : g_bad_data_width
        $fatal(1, "DATA_WIDTH must be a multiple of PIX_WIDTH");
    end
    if (!is_multiple(H_ACTIVE, PPW)) begin : g_bad_h_active
        $fatal(1, "H_ACTIVE must be a multiple of pixels per word");
    end

    cam_state_t             r_state;
    cam_state_t             w_state_next;
    logic                   w_vs_level, w_vs_rise, w_vs_fall;
    logic                   w_href_level, w_href_rise, w_href_fall;
    logic                   w_start, w_done, w_skip, w_abort;
    logic                   w_loss, w_accept, w_word_done, w_line_end, w_pad, w_count_line, w_last_line;
    logic [DATA_WIDTH-1:0]  r_pack, r_word, w_pack_next;
    logic [K_W-1:0]         r_k;
    logic                   r_push;
    logic [PIX_CNT_W-1:0]   r_pix_cnt;
    logic [LINE_W-1:0]      r_line_cnt;

    sync_edge u_vsync_edge (
        .wr_clk  (wr_clk),
        .rst     (rst),
        .i_d     (i_vsync),
        .o_level (w_vs_level),
        .o_rise  (w_vs_rise),
        .o_fall  (w_vs_fall)
    );

    sync_edge u_href_edge (
        .wr_clk  (wr_clk),
        .rst     (rst),
        .i_d     (i_href),
        .o_level (w_href_level),
        .o_rise  (w_href_rise),
        .o_fall  (w_href_fall)
    );

    // A push seen by a full FIFO is lost; pixels stop being taken from that moment on.
    assign w_loss       = o_fifo_wr_en & i_fifo_full;
    assign w_accept     = (r_state == ACTIVE) & w_href_level & i_pix_valid & ~w_vs_level & ~w_loss;
    assign w_word_done  = w_accept & (r_k == K_W'(PPW - 1));
    assign w_line_end   = (r_state == ACTIVE) & w_href_fall & ~w_vs_rise & ~w_loss;
    assign w_pad        = w_line_end & (r_k != '0);
    assign w_count_line = ((r_state == ACTIVE) | (r_state == DROP)) & w_href_fall & ~w_vs_rise;
    assign w_last_line  = (r_line_cnt + 1'b1) == LINE_W'(V_ACTIVE);

    // Current word with the incoming pixel dropped into slot k (first pixel in the LSBs).
    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[r_k*PIX_WIDTH +: PIX_WIDTH] = i_pix_data;
    end

    // Frame state register.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) r_state <= WAIT_VS;
        else     r_state <= w_state_next;
    end

    // Frame sequencing: next state plus the single-cycle frame events.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_skip       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            WAIT_VS: begin
                if (w_vs_rise) w_state_next = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (w_vs_fall) begin
                    if (i_fifo_prog_full) begin
                        w_skip       = 1'b1;
                        w_state_next = WAIT_VS;
                    end else begin
                        w_start      = 1'b1;
                        w_state_next = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (w_vs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = WAIT_FRAME;
                end else if (w_href_fall && w_last_line) begin
                    w_done       = 1'b1;
                    w_state_next = WAIT_VS;
                end else if (w_loss) begin
                    w_state_next = DROP;
                end
            end
            DROP: begin
                if (w_vs_rise) begin
                    w_state_next = WAIT_FRAME;
                end else if (w_href_fall && w_last_line) begin
                    w_done       = 1'b1;
                    w_state_next = WAIT_VS;
                end
            end
            default: w_state_next = WAIT_VS;
        endcase
    end

    // Registered frame pulses, frame counter and the sticky error flags.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_skip  <= 1'b0;
            o_frame_cnt   <= '0;
            o_overflow    <= 1'b0;
            o_line_err    <= 1'b0;
        end else begin
            o_frame_start <= w_start;
            o_frame_done  <= w_done;
            o_frame_skip  <= w_skip;
            if (w_start) o_frame_cnt <= o_frame_cnt + 16'd1;
            if (w_start)     o_overflow <= 1'b0;
            else if (w_loss) o_overflow <= 1'b1;
            if (w_start) o_line_err <= 1'b0;
            else if (w_abort || (w_line_end && (r_pix_cnt != PIX_CNT_W'(H_ACTIVE)))) o_line_err <= 1'b1;
        end
    end

    // Pixel packer: completed words are staged one cycle before reaching the FIFO port.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            r_pack <= '0;
            r_word <= '0;
            r_k    <= '0;
            r_push <= 1'b0;
        end else begin
            r_push <= w_word_done;
            if (w_start || w_abort || w_line_end) begin
                r_pack <= '0;
                r_k    <= '0;
            end else if (w_word_done) begin
                r_word <= w_pack_next;
                r_pack <= '0;
                r_k    <= '0;
            end else if (w_accept) begin
                r_pack <= w_pack_next;
                r_k    <= r_k + 1'b1;
            end
        end
    end

    // Pixel and line counters; the pixel count restarts at every line start and saturates.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
        end else begin
            if (w_start || w_abort || w_line_end) r_pix_cnt <= '0;
            else if (w_href_rise)                 r_pix_cnt <= w_accept ? PIX_CNT_W'(1) : '0;
            else if (w_accept && (r_pix_cnt != '1)) r_pix_cnt <= r_pix_cnt + 1'b1;
            if (w_start)           r_line_cnt <= '0;
            else if (w_count_line) r_line_cnt <= r_line_cnt + 1'b1;
        end
    end

    // FIFO write port: a staged full word, or the zero-padded tail of a line.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            o_fifo_wr_en <= 1'b0;
            o_fifo_din   <= '0;
        end else begin
            o_fifo_wr_en <= 1'b0;
            if (r_push && !w_loss) begin
                o_fifo_wr_en <= 1'b1;
                o_fifo_din   <= r_word;
            end else if (w_pad) begin
                o_fifo_wr_en <= 1'b1;
                o_fifo_din   <= r_pack;
            end
        end
    end

endmodule

// File: tb/tb_cam_fifo_writer.sv
// Directed scoreboard bench for cam_fifo_writer with an 8x2 frame and 4 pixels per word.
module tb_cam_fifo_writer;

   logic        clk;
   logic        rst;
   logic        vsync;
   logic        href;
   logic        pixValid;
   logic [15:0] pixData;
   logic        fifoFull;
   logic        fifoProgFull;
   logic        fifoWrEn;
   logic [63:0] fifoDin;
   logic        frameStart;
   logic        frameDone;
   logic        frameSkip;
   logic        overflow;
   logic        lineErr;
   logic [15:0] frameCnt;

   int vectors     = 0;
   int miscompares = 0;
   int pushCount   = 0;
   int startCount  = 0;
   int doneCount   = 0;
   int skipCount   = 0;
   int pushBase, startBase, doneBase, skipBase;
   bit ovfPending  = 1'b0;
   logic [63:0] expQ[$];

   cam_fifo_writer #(
      .PIX_WIDTH  (16),
      .DATA_WIDTH (64),
      .H_ACTIVE   (8),
      .V_ACTIVE   (2)
   ) dut (
      .wr_clk           (clk),
      .rst              (rst),
      .i_vsync          (vsync),
      .i_href           (href),
      .i_pix_valid      (pixValid),
      .i_pix_data       (pixData),
      .i_fifo_full      (fifoFull),
      .i_fifo_prog_full (fifoProgFull),
      .o_fifo_wr_en     (fifoWrEn),
      .o_fifo_din       (fifoDin),
      .o_frame_start    (frameStart),
      .o_frame_done     (frameDone),
      .o_frame_skip     (frameSkip),
      .o_overflow       (overflow),
      .o_line_err       (lineErr),
      .o_frame_cnt      (frameCnt)
   );

   // Free-running 100 MHz-style bench clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports a mismatch with its tag.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Scoreboard monitor: pops the expected word on every FIFO write and counts frame pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (ovfPending) begin
            checkOutput("overflow_next_cycle", {63'd0, overflow}, 64'd1);
            ovfPending = 1'b0;
         end
         if (fifoWrEn) begin
            pushCount++;
            if (expQ.size() == 0) checkOutput("unexpected_push", {63'd0, fifoWrEn}, 64'd0);
            else                  checkOutput("push_data", fifoDin, expQ.pop_front());
            if (fifoFull) ovfPending = 1'b1;
         end
         if (frameStart) startCount++;
         if (frameDone)  doneCount++;
         if (frameSkip)  skipCount++;
      end
   end

   // Snapshot the monitor counters at the start of a scenario.
   task automatic markCounts();
      pushBase  = pushCount;
      startBase = startCount;
      doneBase  = doneCount;
      skipBase  = skipCount;
   endtask

   // Raw vsync pulse; the frame event must appear exactly two edges after the fall.
   task automatic startFrame(input bit expectSkip);
      vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1 vsync = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      if (expectSkip) begin
         checkOutput("frame_skip_latency", {63'd0, frameSkip}, 64'd1);
         checkOutput("no_start_on_skip", {63'd0, frameStart}, 64'd0);
      end else begin
         checkOutput("frame_start_latency", {63'd0, frameStart}, 64'd1);
         checkOutput("no_skip_on_start", {63'd0, frameSkip}, 64'd0);
      end
      @(posedge clk);
      #1 checkOutput("frame_pulse_width", {63'd0, frameStart | frameSkip}, 64'd0);
   endtask

   // One camera line of nPix pixels valued base+1..base+nPix; queues the words it should produce.
   task automatic applyStimulus(input int nPix, input logic [15:0] base, input bit expectWords,
                                input int fullAt, input bit abortLine, input bit checkLatency);
      logic [63:0] word;
      logic [63:0] firstWord;
      word      = '0;
      firstWord = '0;
      href = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < nPix; i++) begin
         if (i == fullAt) fifoFull = 1'b1;
         pixData  = base + 16'(i + 1);
         pixValid = 1'b1;
         word[(i % 4) * 16 +: 16] = pixData;
         if ((i % 4) == 3) begin
            if (expectWords) expQ.push_back(word);
            if (i == 3) firstWord = word;
            word = '0;
         end
         @(posedge clk);
         #1;
         if (checkLatency && i == 3) checkOutput("push_latency_early", {63'd0, fifoWrEn}, 64'd0);
         if (checkLatency && i == 4) begin
            checkOutput("push_latency", {63'd0, fifoWrEn}, 64'd1);
            checkOutput("first_word", fifoDin, firstWord);
         end
      end
      pixValid = 1'b0;
      pixData  = '0;
      if (abortLine) begin
         vsync = 1'b1;
         repeat (3) @(posedge clk);
         #1 href = 1'b0;
      end else begin
         href = 1'b0;
         if (expectWords && (nPix % 4) != 0) expQ.push_back(word);
      end
      repeat (4) @(posedge clk);
      #1 fifoFull = 1'b0;
   endtask

   // Directed sequence of capture scenarios.
   initial begin
      rst = 1'b1; vsync = 1'b0; href = 1'b0; pixValid = 1'b0; pixData = '0;
      fifoFull = 1'b0; fifoProgFull = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_wr_en", {63'd0, fifoWrEn}, 64'd0);
      checkOutput("reset_din", fifoDin, 64'd0);
      checkOutput("reset_frame_cnt", {48'd0, frameCnt}, 64'd0);
      checkOutput("reset_overflow", {63'd0, overflow}, 64'd0);
      checkOutput("reset_line_err", {63'd0, lineErr}, 64'd0);
      checkOutput("reset_pulses", {61'd0, frameStart, frameDone, frameSkip}, 64'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] nominal frame");
      markCounts();
      startFrame(1'b0);
      applyStimulus(8, 16'h0000, 1'b1, -1, 1'b0, 1'b1);
      applyStimulus(8, 16'h0008, 1'b1, -1, 1'b0, 1'b0);
      checkOutput("nominal_pushes", 64'(pushCount - pushBase), 64'd4);
      checkOutput("nominal_starts", 64'(startCount - startBase), 64'd1);
      checkOutput("nominal_dones", 64'(doneCount - doneBase), 64'd1);
      checkOutput("nominal_frame_cnt", {48'd0, frameCnt}, 64'd1);
      checkOutput("nominal_line_err", {63'd0, lineErr}, 64'd0);
      checkOutput("nominal_overflow", {63'd0, overflow}, 64'd0);

      $display("[TB] short line");
      markCounts();
      startFrame(1'b0);
      applyStimulus(6, 16'h00A0, 1'b1, -1, 1'b0, 1'b0);
      checkOutput("short_line_err", {63'd0, lineErr}, 64'd1);
      applyStimulus(8, 16'h00B0, 1'b1, -1, 1'b0, 1'b0);
      checkOutput("short_pushes", 64'(pushCount - pushBase), 64'd4);
      checkOutput("short_dones", 64'(doneCount - doneBase), 64'd1);
      checkOutput("short_frame_cnt", {48'd0, frameCnt}, 64'd2);

      $display("[TB] overflow");
      markCounts();
      startFrame(1'b0);
      applyStimulus(8, 16'h0020, 1'b1, 6, 1'b0, 1'b0);
      checkOutput("overflow_set", {63'd0, overflow}, 64'd1);
      applyStimulus(8, 16'h0030, 1'b0, -1, 1'b0, 1'b0);
      checkOutput("overflow_pushes", 64'(pushCount - pushBase), 64'd2);
      checkOutput("overflow_dones", 64'(doneCount - doneBase), 64'd1);
      checkOutput("overflow_sticky", {63'd0, overflow}, 64'd1);
      markCounts();
      startFrame(1'b0);
      checkOutput("overflow_cleared", {63'd0, overflow}, 64'd0);
      applyStimulus(8, 16'h0040, 1'b1, -1, 1'b0, 1'b0);
      applyStimulus(8, 16'h0048, 1'b1, -1, 1'b0, 1'b0);
      checkOutput("recover_pushes", 64'(pushCount - pushBase), 64'd4);
      checkOutput("recover_frame_cnt", {48'd0, frameCnt}, 64'd4);

      $display("[TB] skip");
      markCounts();
      fifoProgFull = 1'b1;
      startFrame(1'b1);
      fifoProgFull = 1'b0;
      applyStimulus(8, 16'h0050, 1'b0, -1, 1'b0, 1'b0);
      applyStimulus(8, 16'h0058, 1'b0, -1, 1'b0, 1'b0);
      checkOutput("skip_pulses", 64'(skipCount - skipBase), 64'd1);
      checkOutput("skip_pushes", 64'(pushCount - pushBase), 64'd0);
      checkOutput("skip_starts", 64'(startCount - startBase), 64'd0);
      checkOutput("skip_frame_cnt", {48'd0, frameCnt}, 64'd4);

      $display("[TB] abort");
      markCounts();
      startFrame(1'b0);
      applyStimulus(6, 16'h0060, 1'b1, -1, 1'b1, 1'b0);
      checkOutput("abort_pushes", 64'(pushCount - pushBase), 64'd1);
      checkOutput("abort_line_err", {63'd0, lineErr}, 64'd1);
      checkOutput("abort_no_done", 64'(doneCount - doneBase), 64'd0);
      startFrame(1'b0);
      checkOutput("abort_line_err_cleared", {63'd0, lineErr}, 64'd0);
      checkOutput("abort_frame_cnt", {48'd0, frameCnt}, 64'd6);
      applyStimulus(8, 16'h0070, 1'b1, -1, 1'b0, 1'b0);
      applyStimulus(8, 16'h0078, 1'b1, -1, 1'b0, 1'b0);
      checkOutput("abort_next_dones", 64'(doneCount - doneBase), 64'd1);

      $display("[TB] reset mid-line");
      startFrame(1'b0);
      markCounts();
      href = 1'b1;
      @(posedge clk);
      #1 pixValid = 1'b1; pixData = 16'h0081;
      @(posedge clk);
      #1 pixData = 16'h0082;
      @(posedge clk);
      #1 pixValid = 1'b0; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("midreset_wr_en", {63'd0, fifoWrEn}, 64'd0);
      checkOutput("midreset_din", fifoDin, 64'd0);
      checkOutput("midreset_frame_cnt", {48'd0, frameCnt}, 64'd0);
      checkOutput("midreset_flags", {62'd0, overflow, lineErr}, 64'd0);
      checkOutput("midreset_pulses", {61'd0, frameStart, frameDone, frameSkip}, 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         pixValid = 1'b1;
         pixData  = 16'h0083 + 16'(i);
         @(posedge clk);
         #1;
      end
      pixValid = 1'b0;
      href     = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      applyStimulus(8, 16'h0088, 1'b0, -1, 1'b0, 1'b0);
      checkOutput("midreset_no_pushes", 64'(pushCount - pushBase), 64'd0);
      checkOutput("midreset_no_frame", 64'(startCount - startBase + doneCount - doneBase), 64'd0);
      markCounts();
      startFrame(1'b0);
      applyStimulus(8, 16'h0090, 1'b1, -1, 1'b0, 1'b0);
      applyStimulus(8, 16'h0098, 1'b1, -1, 1'b0, 1'b0);
      checkOutput("postreset_pushes", 64'(pushCount - pushBase), 64'd4);
      checkOutput("postreset_frame_cnt", {48'd0, frameCnt}, 64'd1);
      checkOutput("postreset_dones", 64'(doneCount - doneBase), 64'd1);

      checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cam_fifo_writer.md
# cam_fifo_writer

Camera-side front end of the capture path, running entirely in the sensor pixel-clock domain (`wr_clk`). It frames the incoming pixel stream on `vsync`/`href`, packs `PIX_WIDTH` pixels into `DATA_WIDTH`-bit words and writes them into the capture async FIFO through its write port. The FIFO's `full` and `prog_full` outputs are honoured, and frame-level status is reported for the DDR write engine on the far side of the FIFO.

## Interface
- `PIX_WIDTH`, 16, pixel width (RGB565).
- `DATA_WIDTH`, 64, FIFO word width; must be a multiple of `PIX_WIDTH`.
- `H_ACTIVE`, 640, pixels per line; must be a multiple of PPW = `DATA_WIDTH/PIX_WIDTH`.
- `V_ACTIVE`, 480, lines per frame.
- `wr_clk`  in  1  pixel clock (24 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `vsync`  in  1  frame sync, active-high, high between frames.
- `href`  in  1  line valid, active-high.
- `pix_valid`  in  1  qualifies `pix_data`.
- `pix_data`  in  `PIX_WIDTH`  pixel.
- `fifo_full`  in  1  FIFO `full`.
- `fifo_prog_full`  in  1  FIFO `prog_full`.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_din`  out  `DATA_WIDTH`  packed word.
- `frame_start`  out  1  one-cycle pulse, frame accepted.
- `frame_done`  out  1  one-cycle pulse, `V_ACTIVE` lines completed.
- `frame_skip`  out  1  one-cycle pulse, frame skipped because `prog_full` was high at its start.
- `overflow`  out  1  sticky; a word was lost to `fifo_full`. Cleared at the next `frame_start`.
- `line_err`  out  1  sticky; a line length ≠ `H_ACTIVE`, or vsync aborted a frame. Cleared at `frame_start`.
- `frame_cnt`  out  16  accepted frames, wraps at 0xFFFF.

## Operation
- `vsync` and `href` are registered once. Edges are detected on the registered versions.
- **WAIT_VS:** wait for a vsync rise, then go to WAIT_FRAME.
- **WAIT_FRAME:** wait for a vsync fall.
  - If `fifo_prog_full` is high at the fall: pulse `frame_skip` and go to WAIT_VS.
  - Otherwise: pulse `frame_start`, increment `frame_cnt`, clear `overflow` and `line_err`, zero the counters, go to ACTIVE.
- **ACTIVE:**
  - A pixel is accepted when registered `href` is high and `pix_valid` is high. Pixel k of a word occupies bits `[k*PIX_WIDTH +: PIX_WIDTH]`, with the first pixel in the LSBs.
  - When the PPW-th pixel is accepted, the word is pushed and the packer restarts at k=0.
  - On an `href` fall:
    - If the pixel count is not a multiple of PPW, the partial word is pushed zero-padded.
    - If the pixel count ≠ `H_ACTIVE`, set `line_err`.
    - Increment the line counter.
    - When the counter reaches `V_ACTIVE`, pulse `frame_done` and go to WAIT_VS.
  - A vsync rise in ACTIVE aborts the frame: discard the partial word, set `line_err`, no `frame_done`, go to WAIT_FRAME.
- **Overflow:** a push made while `fifo_full` is high is lost. On that event set `overflow` and go to DROP. Words are never retried.
- **DROP:** ignore pixels, but keep counting `href` falls. Leave on reaching `V_ACTIVE` lines (pulse `frame_done`, go to WAIT_VS) or on a vsync rise (go to WAIT_FRAME).
- **Counter widths:** pixel counter is clog2(`H_ACTIVE`)+1 bits and saturates at all-ones. Line counter is clog2(`V_ACTIVE`)+1 bits.

## Timing
- **Reset values:**
  - `fifo_wr_en`, `fifo_din`, all pulses, `overflow`, `line_err`: 0.
  - `frame_cnt`: 0.
  - State: WAIT_VS.
  - A frame in progress at reset release is ignored until a full vsync rise/fall pair is seen.
- **Push latency:** the pixel completing a word is sampled at edge N. `fifo_wr_en`=1 and `fifo_din` are valid after edge N+1, for exactly one cycle.
- **Zero-pad flush:** `fifo_wr_en` goes high one cycle after the registered `href` fall.
- **Loss test:** `fifo_full` is evaluated in the cycle `fifo_wr_en` is high. `overflow` rises the following cycle.
- **Sync latency:** `frame_start`, `frame_done` and `frame_skip` are asserted two cycles after the raw `vsync`/`href` edge (one cycle for the input register, one for the output register).
- **Back-to-back pushes:** allowed every PPW pixels, i.e. at most one per PPW cycles.
- **href fall coinciding with the PPW-th pixel:** exactly one word is pushed, with no extra pad word.
- `fifo_wr_en` is never asserted outside ACTIVE, except for the final push of a word completed on the last accepted pixel.

## Structure
- **Package `cam_pkg`:**
  - State enum: WAIT_VS, WAIT_FRAME, ACTIVE, DROP.
  - Function `ppw()`.
  - Elaboration checks on parameter divisibility.
- **Sub-module `sync_edge`:** one register plus rise/fall pulse generation. Instantiated for `vsync` and for `href`.

## Test plan
Bench parameters: `H_ACTIVE`=8, `V_ACTIVE`=2, PPW=4.

- **Nominal frame:** pixels 0x0001..0x0010 over 2 lines, FIFO never full.
  - 4 pushes.
  - First word = 0x0004_0003_0002_0001.
  - 1 `frame_start`, 1 `frame_done`; `frame_cnt`=1.
  - No errors.
- **Short line:** line 0 has 6 pixels (0xA1..0xA6).
  - Second word = 0x0000_0000_00A6_00A5.
  - `line_err`=1.
  - `frame_done` is still pulsed after line 1.
- **Overflow:** `fifo_full` held high during the 2nd push.
  - `overflow`=1 the next cycle.
  - No further `fifo_wr_en` in that frame.
  - `frame_done` is pulsed.
  - Next frame: `overflow` cleared at `frame_start`.
- **Skip:** `fifo_prog_full`=1 at the vsync fall.
  - `frame_skip` pulse.
  - Zero pushes; `frame_cnt` unchanged.
- **Abort:** vsync rises after 6 pixels of line 0.
  - 1 push only; `line_err`=1; no `frame_done`.
  - The next vsync fall pulses `frame_start`.
- **Reset mid-line:** `rst` asserted after pixel 2, then released with `href` high.
  - All outputs are 0.
  - No push until a vsync rise then fall.
